// File: rtl/rf_pkg.sv
// Shared constants and the writeback payload type for the register-file writer.
package rf_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned NREGS      = 2 ** ADDR_W;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO; head reads as zero while empty. DEPTH must be a power of two >= 2.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port owner: arbitrates ALU/load results into a buffer,
// retires one write per cycle and tracks outstanding writes per register.
module rf_writeback_ctrl
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_wreg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_wreg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_wreg,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wreg,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] chk_reg1,
    input  logic [ADDR_W-1:0] chk_reg2,
    output logic              busy1,
    output logic              busy2,
    output logic [NREGS-1:0]  sb_busy,
    output logic              fifo_full,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_entry_t        push_entry;
    wb_entry_t        head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic             push;
    logic             fifo_empty;
    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic             err_set;

    // Load results win over ALU results; only one push per cycle.
    assign mem_ready  = !fifo_full;
    assign alu_ready  = !fifo_full && !mem_valid;
    assign push       = (mem_valid || alu_valid) && !fifo_full;
    assign push_entry = mem_valid ? '{wreg: mem_wreg, data: mem_data}
                                  : '{wreg: alu_wreg, data: alu_data};

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_entry),
        .pop       (rf_we),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_bits)
    );

    assign head_entry = wb_entry_t'(head_bits);
    assign rf_we      = !fifo_empty;
    assign rf_wreg    = head_entry.wreg;
    assign rf_wdata   = head_entry.data;

    // Pending-write counters: issue increments, retire decrements, both cancel.
    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (issue_en && (issue_wreg == ADDR_W'(i)) &&
                !(rf_we && (rf_wreg == ADDR_W'(i)))) begin
                if (cnt_q[i] == CNT_MAX) err_set = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (rf_we && (rf_wreg == ADDR_W'(i)) &&
                         !(issue_en && (issue_wreg == ADDR_W'(i)))) begin
                if (cnt_q[i] == '0) err_set = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sb_err <= 1'b0;
            for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
        end else begin
            sb_err <= sb_err || err_set;
            for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) sb_busy[i] = (cnt_q[i] != '0);
    end

    assign busy1 = sb_busy[chk_reg1];
    assign busy2 = sb_busy[chk_reg2];

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: per-cycle vector table plus a queue model of
// accepted results and a counter model of the pending-write scoreboard.
module tb_rf_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        alu_valid, mem_valid, issue_en;
    logic        alu_ready, mem_ready;
    logic [2:0]  alu_wreg, mem_wreg, issue_wreg, chk_reg1, chk_reg2;
    logic [15:0] alu_data, mem_data;
    logic        rf_we, busy1, busy2, fifo_full, sb_err;
    logic [2:0]  rf_wreg;
    logic [15:0] rf_wdata;
    logic [7:0]  sb_busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    rf_writeback_ctrl dut (
        .clk(clk), .rstn(rstn),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wreg(alu_wreg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wreg(mem_wreg), .mem_data(mem_data),
        .issue_en(issue_en), .issue_wreg(issue_wreg),
        .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .busy1(busy1), .busy2(busy2),
        .sb_busy(sb_busy), .fifo_full(fifo_full), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  wreg;
        logic [15:0] data;
    } ent_t;

    typedef struct {
        logic        av; logic [2:0] aw; logic [15:0] ad;
        logic        mv; logic [2:0] mw; logic [15:0] md;
        logic        ie; logic [2:0] iw;
        logic [2:0]  c1; logic [2:0] c2;
        logic        ear; logic emr; logic ewe;
    } vec_t;

    ent_t q[$];
    int   mcnt[8];
    bit   merr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_busy();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (mcnt[i] != 0);
        return b;
    endfunction

    // Model step at each rising edge, using the inputs held across that edge.
    task automatic model_update();
        bit   ret;
        ent_t hd;
        if (!rstn) begin
            q.delete();
            for (int i = 0; i < 8; i++) mcnt[i] = 0;
            merr = 1'b0;
            return;
        end
        ret = (q.size() != 0);
        hd  = ret ? q[0] : '0;
        for (int i = 0; i < 8; i++) begin
            bit inc, dec;
            inc = issue_en && (issue_wreg == 3'(i));
            dec = ret && (hd.wreg == 3'(i));
            if (inc && !dec) begin
                if (mcnt[i] == 3) merr = 1'b1; else mcnt[i]++;
            end else if (dec && !inc) begin
                if (mcnt[i] == 0) merr = 1'b1; else mcnt[i]--;
            end
        end
        if (q.size() < 2) begin
            if (mem_valid)      q.push_back('{wreg: mem_wreg, data: mem_data});
            else if (alu_valid) q.push_back('{wreg: alu_wreg, data: alu_data});
        end
        if (ret) void'(q.pop_front());
    endtask

    task automatic check_all();
        ent_t       exp_h;
        logic [7:0] mb;
        exp_h = (q.size() != 0) ? q[0] : '0;
        mb    = model_busy();
        check("rf_we", 64'(rf_we), 64'(q.size() != 0));
        check("rf_head", 64'({rf_wreg, rf_wdata}), 64'(exp_h));
        check("fifo_full", 64'(fifo_full), 64'(q.size() == 2));
        check("mem_ready", 64'(mem_ready), 64'(q.size() < 2));
        check("alu_ready", 64'(alu_ready), 64'((q.size() < 2) && !mem_valid));
        check("sb_busy", 64'(sb_busy), 64'(mb));
        check("busy1", 64'(busy1), 64'(mb[chk_reg1]));
        check("busy2", 64'(busy2), 64'(mb[chk_reg2]));
        check("sb_err", 64'(sb_err), 64'(merr));
    endtask

    initial forever begin
        @(posedge clk);
        model_update();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) check_all();
    end

    function automatic vec_t v(input logic av, input logic [2:0] aw, input logic [15:0] ad,
                               input logic mv, input logic [2:0] mw, input logic [15:0] md,
                               input logic ie, input logic [2:0] iw, input logic [2:0] c1,
                               input logic ear, input logic emr, input logic ewe);
        vec_t r;
        r.av = av; r.aw = aw; r.ad = ad; r.mv = mv; r.mw = mw; r.md = md;
        r.ie = ie; r.iw = iw; r.c1 = c1; r.c2 = 3'd0;
        r.ear = ear; r.emr = emr; r.ewe = ewe;
        return r;
    endfunction

    task automatic idle_in();
        alu_valid = 0; alu_wreg = 0; alu_data = 0;
        mem_valid = 0; mem_wreg = 0; mem_data = 0;
        issue_en = 0; issue_wreg = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = v(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd0, 1, 1, 0);
        vecs[1]  = v(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd3, 3'd3, 1, 1, 0);
        vecs[2]  = v(1, 3'd3, 16'hA5A5, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd3, 1, 1, 0);
        vecs[3]  = v(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd3, 1, 1, 1);
        vecs[4]  = v(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd1, 3'd3, 1, 1, 0);
        vecs[5]  = v(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 1, 3'd2, 3'd1, 0, 1, 0);
        vecs[6]  = v(1, 3'd1, 16'h1111, 0, 3'd0, 16'h0000, 1, 3'd4, 3'd1, 1, 1, 1);
        vecs[7]  = v(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd6, 3'd1, 1, 1, 1);
        vecs[8]  = v(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd5, 3'd4, 1, 1, 0);
        vecs[9]  = v(1, 3'd5, 16'h5555, 1, 3'd4, 16'h4444, 1, 3'd7, 3'd4, 0, 1, 0);
        vecs[10] = v(1, 3'd5, 16'h5555, 1, 3'd6, 16'h6666, 0, 3'd0, 3'd5, 0, 1, 1);
        vecs[11] = v(1, 3'd5, 16'h5555, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd6, 1, 1, 1);
        vecs[12] = v(1, 3'd7, 16'h7777, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd7, 1, 1, 1);
        vecs[13] = v(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd7, 1, 1, 1);
        vecs[14] = v(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 3'd7, 1, 1, 0);

        rstn = 0;
        idle_in();
        chk_reg1 = 0; chk_reg2 = 0;
        repeat (2) next_cycle();
        rstn = 1;
        chk_en = 1;

        for (int i = 0; i < 15; i++) begin
            alu_valid = vecs[i].av; alu_wreg = vecs[i].aw; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_wreg = vecs[i].mw; mem_data = vecs[i].md;
            issue_en = vecs[i].ie; issue_wreg = vecs[i].iw;
            chk_reg1 = vecs[i].c1; chk_reg2 = vecs[i].c2;
            @(negedge clk);
            check($sformatf("vec%0d_alu_ready", i), 64'(alu_ready), 64'(vecs[i].ear));
            check($sformatf("vec%0d_mem_ready", i), 64'(mem_ready), 64'(vecs[i].emr));
            check($sformatf("vec%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].ewe));
            next_cycle();
        end

        // Issue and retire of r5 in the same cycle leaves its counter at 1.
        idle_in(); issue_en = 1; issue_wreg = 3'd5; chk_reg1 = 3'd5; chk_reg2 = 3'd2;
        next_cycle();
        idle_in(); alu_valid = 1; alu_wreg = 3'd5; alu_data = 16'hBEEF;
        next_cycle();
        idle_in(); issue_en = 1; issue_wreg = 3'd5;
        @(negedge clk);
        check("same_cycle_we", 64'({rf_we, rf_wreg, rf_wdata}), 64'({1'b1, 3'd5, 16'hBEEF}));
        next_cycle();
        idle_in();
        @(negedge clk);
        check("same_cycle_busy1", 64'(busy1), 64'd1);
        check("same_cycle_sb5", 64'(sb_busy[5]), 64'd1);
        alu_valid = 1; alu_wreg = 3'd5; alu_data = 16'hCAFE;
        next_cycle();
        idle_in();
        next_cycle();
        @(negedge clk);
        check("r5_drained", 64'(sb_busy), 64'h00);

        // Saturating r7 counter sets the sticky error; reset clears it with an entry buffered.
        repeat (4) begin
            idle_in(); issue_en = 1; issue_wreg = 3'd7; chk_reg1 = 3'd7;
            next_cycle();
        end
        idle_in();
        @(negedge clk);
        check("sat_err", 64'(sb_err), 64'd1);
        check("sat_busy7", 64'(busy1), 64'd1);
        alu_valid = 1; alu_wreg = 3'd7; alu_data = 16'hD00D;
        next_cycle();
        idle_in();
        rstn = 0;
        @(negedge clk);
        check("pre_reset_we", 64'(rf_we), 64'd1);
        next_cycle();
        rstn = 1;
        @(negedge clk);
        check("post_reset_we", 64'(rf_we), 64'd0);
        check("post_reset_err", 64'(sb_err), 64'd0);
        check("post_reset_busy", 64'(sb_busy), 64'h00);
        repeat (3) next_cycle();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
